instruction_prefetch_buffer: RTL and testbench

- Parametrised next-generation instruction memory with a built-in sequential prefetcher.
- Holds the program in a synchronous-read word array and fetches consecutive words ahead of decode into a small FIFO.
- Presents instructions to decode over a valid/ready handshake and flushes on a branch/jump redirect.
- Has a load port for writing program words at run time.

---
 rtl/instruction_prefetch_buffer.sv | 98 +++++++++
 tb/tb_instruction_prefetch_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_buffer.sv
// instruction_prefetch_buffer: program memory with sequential prefetch into a
// small FIFO, valid/ready delivery to decode and flush on redirect.
module instruction_prefetch_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0,
  parameter     MEM_FILE   = ""
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_en_i,
  input  logic [ADDR_WIDTH-1:0]               load_addr_i,
  input  logic [DATA_WIDTH-1:0]               load_data_i,
  input  logic                                redirect_en_i,
  input  logic [ADDR_WIDTH-1:0]               redirect_pc_i,
  input  logic                                instr_ready_i,
  output logic                                instr_valid_o,
  output logic [DATA_WIDTH-1:0]               instruction_o,
  output logic [ADDR_WIDTH-1:0]               instr_pc_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     occupancy_o
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int OW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q [FIFO_DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rd_pc_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  pop, push, issue;
  logic [OW:0]           credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count both queued and in-flight words so a push can never overflow.
  assign pop    = instr_valid_o & instr_ready_i;
  assign push   = rd_valid_q & ~redirect_en_i;
  assign credit = {1'b0, count_q} + (OW+1)'(rd_valid_q) - (OW+1)'(pop);
  assign issue  = ~redirect_en_i & (credit < (OW+1)'(FIFO_DEPTH));

  always_comb begin
    fetch_pc_d = redirect_en_i ? (redirect_pc_i & ~ADDR_WIDTH'(3))
               : issue ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
    count_d    = redirect_en_i ? '0 : count_q + OW'(push) - OW'(pop);
    head_d     = redirect_en_i ? '0 : pop ? nxt(head_q) : head_q;
    tail_d     = redirect_en_i ? '0 : push ? nxt(tail_q) : tail_q;
  end

  always_ff @(posedge clk) begin
    if (load_en_i) mem[(ADDR_WIDTH-2)'(load_addr_i >> 2)] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (issue) rd_data_q <= mem[fetch_pc_q[ADDR_WIDTH-1:2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
      rd_pc_q    <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_valid_q <= issue;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (issue) rd_pc_q <= fetch_pc_q;
      if (push) begin
        fifo_data_q[tail_q] <= rd_data_q;
        fifo_pc_q[tail_q]   <= rd_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (count_q != OW'(FIFO_DEPTH));
  end

  assign instr_valid_o = (count_q != '0);
  assign instruction_o = fifo_data_q[head_q];
  assign instr_pc_o    = fifo_pc_q[head_q];
  assign occupancy_o   = count_q;
endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// tb_instruction_prefetch_buffer: directed and random stimulus checked against a
// queue-based reference model of the prefetch buffer.
module tb_instruction_prefetch_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        redirect_en = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [9:0]  instr_pc;
  logic [2:0]  occupancy;

  instruction_prefetch_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .redirect_en_i(redirect_en), .redirect_pc_i(redirect_pc),
    .instr_ready_i(instr_ready), .instr_valid_o(instr_valid),
    .instruction_o(instruction), .instr_pc_o(instr_pc), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] pc; logic [31:0] d; } ent_t;
  logic [31:0] mmem [256];
  ent_t        q[$];
  ent_t        inflight;
  bit          infl_v;
  logic [9:0]  fpc;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] old_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    infl_v = 1'b0;
    fpc = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   pop, iss;
    ent_t n;
    if (!rst_n) model_reset();
    else if (redirect_en) begin
      q.delete();
      infl_v = 1'b0;
      fpc = redirect_pc & 10'h3FC;
    end else begin
      pop = (q.size() != 0) && instr_ready;
      iss = (q.size() + int'(infl_v) - int'(pop)) < DEPTH;
      n.pc = fpc;
      n.d = mmem[fpc[9:2]];
      if (pop) void'(q.pop_front());
      if (infl_v) q.push_back(inflight);
      if (q.size() > DEPTH) chk("model_overflow", 64'(q.size()), 64'(DEPTH));
      infl_v = iss;
      if (iss) begin
        inflight = n;
        fpc = fpc + 10'd4;
      end
    end
    if (load_en) mmem[load_addr[9:2]] = load_data;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("valid", 64'(instr_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data", 64'(instruction), 64'(q[0].d));
      chk("pc", 64'(instr_pc), 64'(q[0].pc));
    end
  endtask

  initial begin
    // Program load while held in reset.
    for (int i = 0; i < 256; i++) begin
      load_en = 1'b1;
      load_addr = 10'(i * 4);
      load_data = (i < 8) ? 32'hA000_0000 + 32'(i) : $urandom;
      tick();
    end
    load_en = 1'b0;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_pc", 64'(instr_pc), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);

    // Release with decode ready: valid two edges later, gapless stream.
    rst_n = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("lat1_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("lat2_valid", 64'(instr_valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk("stream_pc", 64'(instr_pc), 64'(k * 4));
      chk("stream_data", 64'(instruction), 64'(32'hA000_0000 + 32'(k)));
      tick();
    end

    // Backpressure from reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("bp_occ", 64'(occupancy), 64'd4);
    chk("bp_pc", 64'(instr_pc), 64'd0);
    chk("bp_data", 64'(instruction), 64'hA000_0000);
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_stream_pc", 64'(instr_pc), 64'(k * 4));
      tick();
    end

    // Redirect while streaming to an unaligned target.
    redirect_en = 1'b1;
    redirect_pc = 10'h105;
    tick();
    chk("redir_v0", 64'(instr_valid), 64'd0);
    redirect_en = 1'b0;
    tick();
    chk("redir_v1", 64'(instr_valid), 64'd0);
    tick();
    chk("redir_pc", 64'(instr_pc), 64'h104);
    chk("redir_data", 64'(instruction), 64'(mmem[65]));

    // Wrap at the top of the address space.
    redirect_en = 1'b1;
    redirect_pc = 10'h3F8;
    tick();
    redirect_en = 1'b0;
    tick();
    tick();
    chk("wrap_pc0", 64'(instr_pc), 64'h3F8);
    tick();
    chk("wrap_pc1", 64'(instr_pc), 64'h3FC);
    tick();
    chk("wrap_pc2", 64'(instr_pc), 64'h000);
    tick();
    chk("wrap_pc3", 64'(instr_pc), 64'h004);

    // Load colliding with the issue of the same word returns old data.
    redirect_en = 1'b1;
    redirect_pc = 10'd40;
    tick();
    redirect_en = 1'b0;
    old_word = mmem[10];
    load_en = 1'b1;
    load_addr = 10'd40;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    tick();
    chk("rbw_pc", 64'(instr_pc), 64'd40);
    chk("rbw_old", 64'(instruction), 64'(old_word));
    redirect_en = 1'b1;
    tick();
    redirect_en = 1'b0;
    tick();
    tick();
    chk("rbw_new", 64'(instruction), 64'hDEAD_BEEF);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_en = ($urandom_range(0, 19) == 0);
      redirect_pc = 10'($urandom);
      load_en = ($urandom_range(0, 9) == 0);
      load_addr = 10'($urandom);
      load_data = $urandom;
      tick();
    end
    load_en = 1'b0;
    redirect_en = 1'b0;

    // Asynchronous reset with three queued entries and one in flight.
    instr_ready = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 10'h080;
    tick();
    redirect_en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(instr_valid), 64'd0);
    chk("async_occ", 64'(occupancy), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("post_rst_v", 64'(instr_valid), 64'd0);
    tick();
    chk("post_rst_valid", 64'(instr_valid), 64'd1);
    chk("post_rst_pc", 64'(instr_pc), 64'd0);
    for (int k = 0; k < 4; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
